bp_be_fe_queue_ckpt: RTL and testbench
======================================

Name: bp_be_fe_queue_ckpt

Overview:
Checkpointing FIFO between the FE and the BE issue/scheduler stage; it holds bp_fe_queue_s packets (fetch or exception) produced by the FE. It keeps three pointers: write (wptr), speculative read (rptr) and commit (cptr). Entries the scheduler has issued but that have not yet committed are retained, so a cache-miss roll can replay them. A commit-time clear discards all contents on an FE redirect.

Parameters:
bp_params_p, e_bp_inv_cfg, processor config; supplies vaddr_width_p and branch_metadata_fwd_width_p.
els_p, 8, queue depth; must be a power of 2, >= 2.
localparam fe_queue_width_lp, `bp_fe_queue_width(vaddr_width_p, branch_metadata_fwd_width_p), entry width.
localparam ptr_width_lp, $clog2(els_p)+1, pointer width including the wrap bit.

Ports:
clk_i  in  1  clock.
reset_i  in  1  synchronous, active-high reset.
clr_v_i  in  1  flush all entries (FE redirect).
fe_queue_i  in  fe_queue_width_lp  enqueue data from FE.
fe_queue_v_i  in  1  enqueue valid.
fe_queue_ready_o  out  1  space available.
fe_queue_o  out  fe_queue_width_lp  entry at rptr.
fe_queue_v_o  out  1  rptr != wptr.
fe_queue_yumi_i  in  1  scheduler consumes head; advances rptr.
fe_queue_roll_i  in  1  rptr <= cptr (replay uncommitted entries).
fe_queue_deq_i  in  1  commit oldest entry; advances cptr.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high on reset_i.
- Reset: wptr = rptr = cptr = 0. Outputs after reset: fe_queue_ready_o = 1, fe_queue_v_o = 0, fe_queue_o = don't-care (X permitted; bench masks it).
- Pointers are ptr_width_lp wide. The low bits index storage; the MSB is the wrap bit. All pointer arithmetic is modulo 2^ptr_width_lp.
- Full: wptr[low] == cptr[low] and wptr[msb] != cptr[msb]. Space is freed only by commit, never by yumi.
- fe_queue_ready_o = ~full. It depends on registered pointers only; no combinational path from inputs.
- Enqueue fires on fe_queue_v_i & fe_queue_ready_o: write mem[wptr], then wptr+1.
- Read is combinational from a flop array, indexed by rptr. There is no write-to-read bypass: data enqueued in cycle t is first visible at fe_queue_o in cycle t+1.
- fe_queue_v_o = (rptr != wptr), i.e. speculative-empty is false.
- Yumi: rptr+1. Yumi while fe_queue_v_o = 0 is illegal; assert and ignore.
- Deq: cptr+1. Deq while cptr == rptr (committing an unissued entry) is illegal; assert and ignore.
- Roll: next rptr = cptr, after any same-cycle deq is applied (next rptr = next cptr).
- Priority per cycle: reset > clr > roll > yumi.
  - Roll and yumi in the same cycle: yumi is ignored.
  - Roll and deq in the same cycle: both apply.
  - Enqueue is independent of roll, deq and yumi.
- clr_v_i: wptr = rptr = cptr = 0 next cycle. Any same-cycle enqueue, yumi, deq or roll is discarded. The FE flushes concurrently, so a dropped enqueue is acceptable.
- Wrap-around: pointers increment through 2*els_p values. The full/empty equations hold across the wrap.
- Reset or clr mid-replay: replay is simply abandoned.

Decomposition:
- No new package types. Reuse bp_fe_queue_s from `declare_bp_fe_be_if.
- Storage: bsg_mem_1r1w (els_p x fe_queue_width_lp, read_write_same_addr_p = 0).
- Natural sub-module: bp_be_fe_queue_ptr. It is one pointer register with increment-enable, load-enable/load-value and clear, instantiated three times.

Test Plan:
- Reset, then enqueue A,B,C on consecutive cycles -> v_o rises 1 cycle after A; the scheduler sees A,B,C in order; ready_o stays 1.
- els_p=8: enqueue 8 with no deq -> ready_o = 0 after the 8th. Yumi all 8 -> ready_o still 0. One deq -> ready_o = 1 next cycle.
- Enqueue 4, yumi 3, deq 1, then assert roll -> rptr = 1; fe_queue_o equals entry 1; three replays yield entries 1, 2, 3.
- Roll, deq and yumi in the same cycle, with cptr = 2 and rptr = 5 -> next cptr = 3 and rptr = 3; yumi is ignored.
- clr_v_i with 5 entries and a concurrent enqueue -> next cycle v_o = 0, ready_o = 1, all pointers 0; the dropped entry never appears.
- 40 enqueue/yumi/deq cycles, els_p=8 (5 wraps) -> data order is preserved; full/empty are correct at every wrap.

Source files
------------

// File: rtl/bp_be_fe_queue_ckpt_pkg.sv
// Shared types for the FE->BE checkpointing queue: the FE queue packet
// layout and the processor-configuration widths it depends on.
package bp_be_fe_queue_ckpt_pkg;

  localparam int vaddr_width_p               = 39;
  localparam int branch_metadata_fwd_width_p = 16;

  typedef enum logic [0:0] {
    e_fe_fetch     = 1'b0,
    e_fe_exception = 1'b1
  } bp_fe_queue_type_e;

  typedef struct packed {
    bp_fe_queue_type_e                       msg_type;
    logic [vaddr_width_p-1:0]                pc;
    logic [31:0]                             instr;
    logic [branch_metadata_fwd_width_p-1:0]  branch_metadata_fwd;
  } bp_fe_queue_s;

  localparam int fe_queue_width_lp = $bits(bp_fe_queue_s);

endpackage

// File: rtl/bp_be_fe_queue_ckpt_ptr.sv
// One queue pointer: wrap-bit counter with clear, load and increment.
// Clear and reset share a path; load beats increment.
module bp_be_fe_queue_ckpt_ptr #(
  parameter int ptr_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   clr_i,
  input  logic                   inc_i,
  input  logic                   ld_i,
  input  logic [ptr_width_p-1:0] ld_val_i,
  output logic [ptr_width_p-1:0] ptr_o
);

  logic [ptr_width_p-1:0] r_ptr;

  // Pointer register; arithmetic wraps naturally modulo 2^ptr_width_p.
  always_ff @(posedge clk_i) begin
    if (reset_i || clr_i) begin
      r_ptr <= '0;
    end else if (ld_i) begin
      r_ptr <= ld_val_i;
    end else if (inc_i) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr_o = r_ptr;

endmodule

// File: rtl/bp_be_fe_queue_ckpt.sv
// Checkpointing FIFO between FE and BE scheduler. Three pointers:
// wptr (write), rptr (speculative issue) and cptr (commit). Issued but
// uncommitted entries stay resident so a roll can replay them; only
// commit frees space. clr_v_i empties the queue on an FE redirect.
module bp_be_fe_queue_ckpt
  import bp_be_fe_queue_ckpt_pkg::*;
#(
  parameter int els_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clr_v_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue_o,
  output logic                         fe_queue_v_o,
  input  logic                         fe_queue_yumi_i,
  input  logic                         fe_queue_roll_i,
  input  logic                         fe_queue_deq_i
);

  localparam int idx_width_lp = $clog2(els_p);
  localparam int ptr_width_lp = idx_width_lp + 1;

  logic [ptr_width_lp-1:0]      w_wptr, w_rptr, w_cptr, w_cptr_nxt;
  logic                         w_full, w_enq, w_yumi, w_deq, w_roll;
  logic [fe_queue_width_lp-1:0] r_mem [els_p];

  // Full when indices match but wrap bits differ; only commit frees space.
  assign w_full = (w_wptr[idx_width_lp-1:0] == w_cptr[idx_width_lp-1:0])
                & (w_wptr[ptr_width_lp-1] != w_cptr[ptr_width_lp-1]);

  assign fe_queue_ready_o = ~w_full;
  assign fe_queue_v_o     = (w_rptr != w_wptr);
  assign fe_queue_o       = r_mem[w_rptr[idx_width_lp-1:0]];

  // clr discards everything else this cycle; roll overrides yumi; illegal
  // yumi/deq requests are dropped.
  assign w_enq  = fe_queue_v_i & ~w_full & ~clr_v_i;
  assign w_roll = fe_queue_roll_i & ~clr_v_i;
  assign w_yumi = fe_queue_yumi_i & fe_queue_v_o & ~w_roll & ~clr_v_i;
  assign w_deq  = fe_queue_deq_i & (w_cptr != w_rptr) & ~clr_v_i;

  // Roll targets the commit pointer after this cycle's deq is applied.
  assign w_cptr_nxt = w_cptr + {{(ptr_width_lp-1){1'b0}}, w_deq};

  bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_wptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (clr_v_i),
    .inc_i    (w_enq),
    .ld_i     (1'b0),
    .ld_val_i ({ptr_width_lp{1'b0}}),
    .ptr_o    (w_wptr)
  );

  bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_rptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (clr_v_i),
    .inc_i    (w_yumi),
    .ld_i     (w_roll),
    .ld_val_i (w_cptr_nxt),
    .ptr_o    (w_rptr)
  );

  bp_be_fe_queue_ckpt_ptr #(.ptr_width_p(ptr_width_lp)) u_cptr (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (clr_v_i),
    .inc_i    (w_deq),
    .ld_i     (1'b0),
    .ld_val_i ({ptr_width_lp{1'b0}}),
    .ptr_o    (w_cptr)
  );

  // Entry storage; data is never reset, and a write is only visible next cycle.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[w_wptr[idx_width_lp-1:0]] <= fe_queue_i;
    end
  end

  // Flag protocol violations from the scheduler; the logic above ignores them.
  always_ff @(posedge clk_i) begin
    if (!reset_i && !clr_v_i) begin
      assert (!(fe_queue_yumi_i && !fe_queue_roll_i && !fe_queue_v_o));
      assert (!(fe_queue_deq_i && (w_cptr == w_rptr)));
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue_ckpt.sv
// Directed bench for the checkpointing FE queue.
module tb_bp_be_fe_queue_ckpt;
  import bp_be_fe_queue_ckpt_pkg::*;

  localparam int W = fe_queue_width_lp;

  logic         clk = 1'b0;
  logic         reset_i, clr_v_i, fe_queue_v_i, fe_queue_yumi_i;
  logic         fe_queue_roll_i, fe_queue_deq_i;
  logic [W-1:0] fe_queue_i;
  logic         fe_queue_ready_o, fe_queue_v_o;
  logic [W-1:0] fe_queue_o;

  int n_pass = 0;
  int n_tot  = 0;

  bp_be_fe_queue_ckpt #(.els_p(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .clr_v_i          (clr_v_i),
    .fe_queue_i       (fe_queue_i),
    .fe_queue_v_i     (fe_queue_v_i),
    .fe_queue_ready_o (fe_queue_ready_o),
    .fe_queue_o       (fe_queue_o),
    .fe_queue_v_o     (fe_queue_v_o),
    .fe_queue_yumi_i  (fe_queue_yumi_i),
    .fe_queue_roll_i  (fe_queue_roll_i),
    .fe_queue_deq_i   (fe_queue_deq_i)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int id);
    logic [W-1:0] v;
    v = '0;
    v[31:0]      = 32'hA5A5_0000 ^ id;
    v[W-1:W-8]   = id[7:0];
    v[55:40]     = 16'h3C00 + id[15:0];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Apply one cycle of controls, then return 1ns after the edge with inputs idle.
  task automatic step(input logic enq, input int id, input logic yumi,
                      input logic deq, input logic roll, input logic clr);
    fe_queue_v_i    = enq;
    fe_queue_i      = mk(id);
    fe_queue_yumi_i = yumi;
    fe_queue_deq_i  = deq;
    fe_queue_roll_i = roll;
    clr_v_i         = clr;
    @(posedge clk);
    #1;
    fe_queue_v_i = 0; fe_queue_yumi_i = 0; fe_queue_deq_i = 0;
    fe_queue_roll_i = 0; clr_v_i = 0;
  endtask

  int ids [512];
  int wc, rc, cc, ok_enq, ok_yumi, ok_deq;

  initial begin
    reset_i = 1; clr_v_i = 0; fe_queue_v_i = 0; fe_queue_yumi_i = 0;
    fe_queue_roll_i = 0; fe_queue_deq_i = 0; fe_queue_i = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 0;
    chk("rst_ready", fe_queue_ready_o, 1);
    chk("rst_v", fe_queue_v_o, 0);

    // A,B,C in order, no bypass
    step(1, 1, 0, 0, 0, 0);
    chk("a_v", fe_queue_v_o, 1);
    chk("a_data", fe_queue_o, mk(1));
    step(1, 2, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0);
    chk("abc_ready", fe_queue_ready_o, 1);
    chk("abc_head", fe_queue_o, mk(1));
    step(0, 0, 1, 0, 0, 0);
    chk("b_data", fe_queue_o, mk(2));
    step(0, 0, 1, 0, 0, 0);
    chk("c_data", fe_queue_o, mk(3));
    step(0, 0, 1, 0, 0, 0);
    chk("abc_empty", fe_queue_v_o, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

    // Fill to 8; yumi does not free space; one deq does
    for (int i = 0; i < 8; i++) begin
      chk("fill_ready", fe_queue_ready_o, 1);
      step(1, 10 + i, 0, 0, 0, 0);
    end
    chk("full_ready", fe_queue_ready_o, 0);
    step(1, 99, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("full_data", fe_queue_o, mk(10 + i));
      step(0, 0, 1, 0, 0, 0);
      chk("yumi_ready", fe_queue_ready_o, 0);
    end
    chk("full_drained_v", fe_queue_v_o, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("deq_ready", fe_queue_ready_o, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0);
    chk("drop_v", fe_queue_v_o, 0);

    // Enqueue 4, yumi 3, deq 1, roll -> replay 1,2,3
    for (int i = 0; i < 4; i++) step(1, 20 + i, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("preroll_data", fe_queue_o, mk(23));
    step(0, 0, 0, 0, 1, 0);
    chk("roll_v", fe_queue_v_o, 1);
    chk("roll_data", fe_queue_o, mk(21));
    step(0, 0, 1, 0, 0, 0);
    chk("replay2", fe_queue_o, mk(22));
    step(0, 0, 1, 0, 0, 0);
    chk("replay3", fe_queue_o, mk(23));
    step(0, 0, 1, 0, 0, 0);
    chk("replay_empty", fe_queue_v_o, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0);

    // cptr=2, rptr=5: roll+deq+yumi -> rptr=cptr=3
    for (int i = 0; i < 6; i++) step(1, 30 + i, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("combo_pre", fe_queue_o, mk(35));
    step(0, 0, 1, 1, 1, 0);
    chk("combo_data", fe_queue_o, mk(33));
    for (int i = 0; i < 5; i++) begin
      chk("combo_ready", fe_queue_ready_o, 1);
      step(1, 36 + i, 0, 0, 0, 0);
    end
    chk("combo_full", fe_queue_ready_o, 0);

    // clr with 5 entries and a concurrent enqueue
    step(0, 0, 0, 0, 0, 1);
    chk("clr0_v", fe_queue_v_o, 0);
    for (int i = 0; i < 5; i++) step(1, 50 + i, 0, 0, 0, 0);
    step(1, 55, 0, 0, 0, 1);
    chk("clr_v", fe_queue_v_o, 0);
    chk("clr_ready", fe_queue_ready_o, 1);
    step(1, 60, 0, 0, 0, 0);
    chk("clr_first", fe_queue_o, mk(60));
    for (int i = 1; i < 8; i++) step(1, 60 + i, 0, 0, 0, 0);
    chk("clr_full", fe_queue_ready_o, 0);
    for (int i = 0; i < 8; i++) begin
      chk("clr_order", fe_queue_o, mk(60 + i));
      step(0, 0, 1, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0, 1);

    // Wrap stress against a small pointer model
    wc = 0; rc = 0; cc = 0;
    for (int k = 0; k < 60; k++) begin
      ok_enq  = (k < 44) && ((wc - cc) < 8);
      ok_yumi = (k % 4 != 3) && (rc != wc);
      ok_deq  = ((k >= 20) || (k % 2 == 0)) && (cc < rc);
      step((k < 44), 100 + k, ok_yumi[0], ok_deq[0], 0, 0);
      if (ok_enq) begin ids[wc] = 100 + k; wc++; end
      if (ok_yumi) rc++;
      if (ok_deq) cc++;
      chk("wrap_v", fe_queue_v_o, (rc != wc));
      chk("wrap_ready", fe_queue_ready_o, ((wc - cc) < 8));
      if (rc != wc) chk("wrap_data", fe_queue_o, mk(ids[rc]));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
